bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan_pkg.sv | 53 +++++
 rtl/bcd_display_scan_bcd_to_seg.sv | 28 ++
 rtl/bcd_display_scan.sv | 140 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scan_pkg.sv
// Shared display definitions for the multiplexed HH:MM:SS seven-segment scan.
//   - Active-low segment patterns for 0-9, the dash shown for non-BCD
//     nibbles, and the all-dark blank pattern.
//   - Mapping from the digit index (0 = rightmost, seconds units) to the
//     time field it belongs to. The field number doubles as the bit
//     position in the blink mask.
//   - Which digits carry the decimal-point field separator.
package bcd_display_scan_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [2:0] LAST_DIGIT = 3'd5;

    // Segment order is {G,F,E,D,C,B,A}, active low.
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_BLANK  = 8'hFF;

    // Entry [v] holds the pattern for decimal digit v.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, // 9
        7'h00, // 8
        7'h78, // 7
        7'h02, // 6
        7'h12, // 5
        7'h19, // 4
        7'h30, // 3
        7'h24, // 2
        7'h79, // 1
        7'h40  // 0
    };

    // Field numbering matches the blink mask bits: 0 seconds, 1 minutes, 2 hours.
    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    function automatic field_e digit_field(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: digit_field = FIELD_SEC;
            3'd2, 3'd3: digit_field = FIELD_MIN;
            default:    digit_field = FIELD_HOUR;
        endcase
    endfunction

    // The separator dot sits on the units digit of the minutes and hours,
    // i.e. between the fields: HH.MM.SS
    function automatic logic digit_has_dp(input logic [2:0] idx);
        digit_has_dp = (idx == 3'd2) || (idx == 3'd4);
    endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// Combinational nibble-to-segment decoder.
//   nibble : 4-bit value to show
//   seg    : active-low {G,F,E,D,C,B,A}; 0-9 decode normally, 10-15 show a dash
module bcd_to_seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = SEG_DIGITS[0];
            4'd1: seg = SEG_DIGITS[1];
            4'd2: seg = SEG_DIGITS[2];
            4'd3: seg = SEG_DIGITS[3];
            4'd4: seg = SEG_DIGITS[4];
            4'd5: seg = SEG_DIGITS[5];
            4'd6: seg = SEG_DIGITS[6];
            4'd7: seg = SEG_DIGITS[7];
            4'd8: seg = SEG_DIGITS[8];
            4'd9: seg = SEG_DIGITS[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed seven-segment driver for an HH:MM:SS BCD clock.
//   CLK100MHZ  : system clock, rising edge
//   reset      : asynchronous, active high; blanks the display immediately
//   BCDtime    : {Ht,Hu,Mt,Mu,St,Su} BCD nibbles
//   blink_mask : fields to flash, bit2 hours / bit1 minutes / bit0 seconds
//   lz_blank   : suppress a leading zero in the hours-tens digit
//   AN         : active-low anodes, AN[0] rightmost; AN[7:6] never driven low
//   SEG        : active-low cathodes {CG..CA}
//   DP         : active-low decimal point, used as the field separator
//
// Each digit slot lasts REFRESH_DIV cycles. The output registers load once
// per slot, on the refresh terminal count, with the digit addressed by the
// current index; the index advances on that same edge. The frame register
// captures BCDtime on the edge where digit 5 is loaded, so all six digits
// of a frame come from one snapshot.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [23:0] BCDtime,
    input  logic [2:0]  blink_mask,
    input  logic        lz_blank,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    import bcd_display_scan_pkg::*;

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [2:0]    digit_idx;
    logic [23:0]   frame;

    logic          refresh_tc;
    logic          blink_tc;
    logic [3:0]    nibble;
    logic [6:0]    seg_digit;
    logic          blank;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign blink_tc   = (blink_cnt == BW'(BLINK_DIV - 1));

    // Refresh counter, digit index and frame capture.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            frame       <= '0;
        end else if (refresh_tc) begin
            refresh_cnt <= '0;
            if (digit_idx == LAST_DIGIT) begin
                digit_idx <= '0;
                frame     <= BCDtime;
            end else begin
                digit_idx <= digit_idx + 3'd1;
            end
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Blink phase generator; phase 0 is the visible half.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_tc) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        nibble = 4'd0;
        case (digit_idx)
            3'd0:    nibble = frame[3:0];
            3'd1:    nibble = frame[7:4];
            3'd2:    nibble = frame[11:8];
            3'd3:    nibble = frame[15:12];
            3'd4:    nibble = frame[19:16];
            3'd5:    nibble = frame[23:20];
            default: nibble = 4'd0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (nibble),
        .seg    (seg_digit)
    );

    // Leading-zero suppression only looks for a literal 0; a non-BCD
    // hours-tens nibble still shows its dash.
    always_comb begin
        blank = 1'b0;
        if (blink_phase && blink_mask[digit_field(digit_idx)]) begin
            blank = 1'b1;
        end
        if (lz_blank && (digit_idx == LAST_DIGIT) && (frame[23:20] == 4'd0)) begin
            blank = 1'b1;
        end
    end

    always_comb begin
        an_next  = AN_BLANK;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!blank) begin
            an_next  = ~(8'd1 << digit_idx);
            seg_next = seg_digit;
            dp_next  = ~digit_has_dp(digit_idx);
        end
    end

    // Outputs stay dark after reset until the first slot boundary, which
    // loads digit 0.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            AN  <= AN_BLANK;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else if (refresh_tc) begin
            AN  <= an_next;
            SEG <= seg_next;
            DP  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 64;

    logic        clk;
    logic        reset;
    logic [23:0] bcd_time;
    logic [2:0]  blink_mask;
    logic        lz_blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int slot;
    logic [23:0] tb_frame;
    logic [15:0] exp_q[$];

    bcd_display_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .BCDtime    (bcd_time),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .AN         (an),
        .SEG        (seg),
        .DP         (dp)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: seg_of = 7'h40;
            4'd1: seg_of = 7'h79;
            4'd2: seg_of = 7'h24;
            4'd3: seg_of = 7'h30;
            4'd4: seg_of = 7'h19;
            4'd5: seg_of = 7'h12;
            4'd6: seg_of = 7'h02;
            4'd7: seg_of = 7'h78;
            4'd8: seg_of = 7'h00;
            4'd9: seg_of = 7'h10;
            default: seg_of = 7'h3F;
        endcase
    endfunction

    // Packs {AN, SEG, DP} for digit idx of frame f.
    function automatic logic [15:0] model(input int idx, input logic [23:0] f,
                                          input bit ph, input logic [2:0] mask,
                                          input bit lz);
        logic [3:0] nib;
        logic [7:0] an_e;
        logic       dk;
        nib = 4'((f >> (4 * idx)) & 24'hF);
        dk  = (ph && mask[idx / 2]) || (lz && idx == 5 && nib == 4'd0);
        if (dk) begin
            model = {8'hFF, 7'h7F, 1'b1};
        end else begin
            an_e  = ~(8'd1 << idx);
            model = {an_e, seg_of(nib), !(idx == 2 || idx == 4)};
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got AN/SEG/DP=%h required %h", name, cyc, act, exp_v);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // A new digit is presented one cycle after each refresh terminal count.
    always @(negedge clk) begin
        if (!reset && cyc > 0 && (cyc % REFRESH_DIV) == 0 && exp_q.size() > 0) begin
            check("slot", {an, seg, dp}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_blank", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        slot     = 0;
        tb_frame = 24'h0;
        // Still dark before the first slot boundary.
        @(negedge clk);
        @(negedge clk);
        check("pre_first_wrap", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    endtask

    task automatic run_slot();
        int m;
        int idx;
        bit ph;
        m   = slot + 1;
        idx = slot % 6;
        ph  = bit'(((REFRESH_DIV * m - 1) / BLINK_DIV) % 2);
        exp_q.push_back(model(idx, tb_frame, ph, blink_mask, lz_blank));
        while (cyc < REFRESH_DIV * m) @(negedge clk);
        if (idx == 5) tb_frame = bcd_time;
        slot++;
    endtask

    task automatic run_slots(input int n);
        for (int i = 0; i < n; i++) run_slot();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        bcd_time   = 24'h0;
        blink_mask = 3'b000;
        lz_blank   = 1'b0;
        slot       = 0;
        tb_frame   = 24'h0;
        #1;
        check("por_blank", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});

        // Plain scan: zero frame first, then 6,5,4,3,2,1 with dots on digits 2 and 4.
        bcd_time = 24'h123456;
        do_reset();
        run_slots(12);

        // Mid-frame change must not tear the frame being shown.
        bcd_time = 24'h095959;
        do_reset();
        run_slots(8);
        bcd_time = 24'h100000;
        run_slots(10);

        // Leading zero suppressed; non-BCD nibble shows a dash.
        bcd_time = 24'h0A0000;
        lz_blank = 1'b1;
        do_reset();
        run_slots(12);

        // Minutes blink; nonzero hours-tens stays lit with lz_blank set.
        bcd_time   = 24'h123456;
        blink_mask = 3'b010;
        do_reset();
        run_slots(40);
        blink_mask = 3'b000;
        lz_blank   = 1'b0;

        // Reset during digit 3's slot.
        bcd_time = 24'h123456;
        do_reset();
        run_slots(10);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_blank", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
        exp_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        slot     = 0;
        tb_frame = 24'h0;
        run_slots(8);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
